bitorder_gen: RTL and testbench
===============================

Name: bitorder_gen

Overview:
Parametrised successor to the chunk-reorder stage in the NES/Ethernet receive path. It accepts a stream of W-bit chunks and groups every K consecutive valid chunks into a word. It re-emits each complete word as K chunks in a run-time-selected order: pass-through, chunk-reversed, bit-reversed-within-chunk, or full word bit reversal. Incomplete trailing words are discarded and counted so downstream framing logic can flag short frames.

Parameters:
W, 4, chunk width in bits (>=1)
K, 2, chunks per word (>=2)
DROP_W, 8, width of saturating dropped-word counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
axiid  in  W  input chunk
axiiv  in  1  input chunk valid; a chunk is accepted on every edge where it is high
mode  in  2  order select, sampled on the edge accepting a word's last chunk: 00 pass, 01 reverse chunk order, 10 reverse bits in each chunk, 11 both (full word bit reversal)
axiod  out  W  output chunk (registered)
axiov  out  1  output chunk valid (registered)
drop  out  1  one-cycle pulse: a partial word was discarded
drop_count  out  DROP_W  number of discarded partial words, saturating at all-ones

Behaviour:
- Reset (rst_n low, async): axiod=0, axiov=0, drop=0, drop_count=0; chunk index=0; capture and emit buffers cleared; any emission in progress is aborted, with no residual output after release.
- Capture: chunk index idx counts 0..K-1. Each accepted chunk is stored at slot idx. On idx=K-1 the word is complete, idx wraps to 0, and the emitter is loaded on that same edge.
- Latency: on the edge accepting chunk K-1, axiov goes high and axiod shows the first output chunk. axiov stays high for exactly K consecutive cycles.
- Output order for arrival chunks c0..c(K-1):
  - mode 00: c0, c1, ..., c(K-1)
  - mode 01: c(K-1), ..., c0
  - mode 10: order as 00, bits of each chunk reversed
  - mode 11: order as 01, bits of each chunk reversed
  - mode is latched per word; changing it mid-word affects only words completing afterwards.
- Back-to-back: continuous axiiv produces continuous axiov with no gap. The emitter can never be reloaded while busy, because the next word needs K more accepted chunks, i.e. at least K cycles. This needs no arbitration, but the bench asserts it.
- axiiv low with idx!=0: the partial word is discarded, idx returns to 0, and drop pulses high on the next cycle. drop_count increments, holding at 2^DROP_W-1. Gaps with idx=0 are not drops.
- An emission in progress always completes all K chunks, regardless of axiiv falling or new chunks arriving.
- When axiov=0, axiod is driven to 0.
- A chunk accepted on the same edge that the emitter sends its final chunk goes to capture normally; capture and emit never interact.
- Pipeline: no backpressure; the sink must accept one chunk per cycle while axiov=1.

Decomposition:
- Package bitorder_pkg:
  - mode enum (MODE_PASS, MODE_REV_CHUNK, MODE_REV_BIT, MODE_REV_ALL)
  - function reversing a W-bit vector
- Top bitorder_gen: capture buffer, idx counter, drop logic.
- One sub-module bitorder_emit: takes K x W word plus latched mode on a load strobe, then runs a K-cycle down/up counter with mux to drive axiod/axiov.

Test Plan:
- W=4,K=2, mode=01, chunks 0101,1101 then idle -> outputs 1101 then 0101 on two consecutive cycles starting the edge of chunk 2; then axiov=0, axiod=0000; drop stays 0.
- W=4,K=2, mode=01, continuous 0101,1101,0001,1010,1100,1101 -> outputs 1101,0101,1010,0001,1101,1100 with axiov high for 6 cycles, no gap.
- W=4,K=2, mode=01, chunks 0101,1101,0100 then axiiv=0 -> outputs 1101,0101; drop pulses once; drop_count=1; 0100 is never emitted.
- W=2,K=4, mode=11, chunks 01,10,11,00 -> outputs 00,11,01,10 (full 8-bit reversal of 00111001 read out); mode=00 on the same data -> 01,10,11,00.
- Reset asserted async mid-emission (after first output chunk) -> axiov=0, axiod=0 immediately; nothing emitted after release until a full new word arrives; drop_count=0.
- DROP_W=2: five single-chunk bursts -> drop pulses 5 times; drop_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/bitorder_pkg.sv
// Shared types and helpers for the chunk reorder stage: the order-select
// encoding and a width-agnostic bit reversal.
package bitorder_pkg;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'b00,
        MODE_REV_CHUNK = 2'b01,
        MODE_REV_BIT   = 2'b10,
        MODE_REV_ALL   = 2'b11
    } mode_e;

    localparam int MAX_BITS = 64;

    // Reverses the low w bits of v; callers truncate the result to their width.
    function automatic logic [MAX_BITS-1:0] reverse_bits(input logic [MAX_BITS-1:0] v,
                                                         input int w);
        logic [MAX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitorder_if.sv
// Chunk stream bundle between a source/sink (master) and the reorder stage (slave).
interface bitorder_if
    import bitorder_pkg::*;
#(
    parameter int W      = 4,
    parameter int DROP_W = 8
);
    logic [W-1:0]      axiid;
    logic              axiiv;
    mode_e             mode;
    logic [W-1:0]      axiod;
    logic              axiov;
    logic              drop;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output axiid, axiiv, mode,
        input  axiod, axiov, drop, drop_count
    );

    modport slave (
        input  axiid, axiiv, mode,
        output axiod, axiov, drop, drop_count
    );
endinterface

// File: rtl/bitorder_emit.sv
// Word emitter: latches a K-chunk word and its order on load, then plays the
// K chunks out on consecutive cycles, the first one on the load edge itself.
module bitorder_emit
    import bitorder_pkg::*;
#(
    parameter int W = 4,
    parameter int K = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [K-1:0][W-1:0] word,
    input  mode_e               mode,
    output logic [W-1:0]        axiod,
    output logic                axiov
);
    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    logic [K-1:0][W-1:0] word_q;
    mode_e               mode_q;
    logic [IDX_W-1:0]    pos;

    logic [K-1:0][W-1:0] src_word;
    mode_e               src_mode;
    logic [IDX_W-1:0]    src_pos;
    logic [IDX_W-1:0]    slot;
    logic [W-1:0]        raw_chunk;
    logic [W-1:0]        chunk;

    // The load edge uses the incoming word directly so output starts with no bubble.
    always_comb begin
        src_word  = load ? word : word_q;
        src_mode  = load ? mode : mode_q;
        src_pos   = load ? '0 : pos;
        slot      = (src_mode == MODE_REV_CHUNK || src_mode == MODE_REV_ALL)
                    ? (LAST - src_pos) : src_pos;
        raw_chunk = src_word[slot];
        chunk     = raw_chunk;
        if (src_mode == MODE_REV_BIT || src_mode == MODE_REV_ALL)
            chunk = W'(reverse_bits(MAX_BITS'(raw_chunk), W));
    end

    // pos != 0 means chunks 1..K-1 of the latched word are still owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            mode_q <= MODE_PASS;
            pos    <= '0;
            axiod  <= '0;
            axiov  <= 1'b0;
        end else if (load) begin
            word_q <= word;
            mode_q <= mode;
            pos    <= IDX_W'(1);
            axiod  <= chunk;
            axiov  <= 1'b1;
        end else if (pos != '0) begin
            axiod  <= chunk;
            axiov  <= 1'b1;
            pos    <= (pos == LAST) ? '0 : pos + IDX_W'(1);
        end else begin
            axiod  <= '0;
            axiov  <= 1'b0;
        end
    end

endmodule

// File: rtl/bitorder_gen.sv
// Groups K valid chunks into a word, hands complete words to the emitter and
// discards/counts partial words broken by a gap in axiiv.
module bitorder_gen
    import bitorder_pkg::*;
#(
    parameter int W      = 4,
    parameter int K      = 2,
    parameter int DROP_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    bitorder_if.slave bus
);
    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    logic [IDX_W-1:0]    idx;
    logic [K-1:0][W-1:0] cap;
    logic [K-1:0][W-1:0] word;
    logic                load;
    logic                drop_q;
    logic [DROP_W-1:0]   drop_count_q;
    logic [W-1:0]        emit_d;
    logic                emit_v;

    assign load = bus.axiiv && (idx == LAST);

    always_comb begin
        word       = cap;
        word[K-1]  = bus.axiid;
    end

    // A gap mid-word throws the partial word away and bumps the saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cap          <= '0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_q <= 1'b0;
            if (bus.axiiv) begin
                cap[idx] <= bus.axiid;
                idx      <= load ? '0 : idx + IDX_W'(1);
            end else if (idx != '0) begin
                idx    <= '0;
                drop_q <= 1'b1;
                if (drop_count_q != '1) drop_count_q <= drop_count_q + DROP_W'(1);
            end
        end
    end

    bitorder_emit #(
        .W (W),
        .K (K)
    ) u_emit (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .word  (word),
        .mode  (bus.mode),
        .axiod (emit_d),
        .axiov (emit_v)
    );

    assign bus.axiod      = emit_d;
    assign bus.axiov      = emit_v;
    assign bus.drop       = drop_q;
    assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_bitorder_gen.sv
// Directed bench for bitorder_gen: three instances cover W=4/K=2, W=2/K=4 and
// a 2-bit drop counter; expected streams are hand-derived per cycle.
module tb_bitorder_gen;
    import bitorder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bitorder_if #(.W(4), .DROP_W(8)) if_a ();
    bitorder_if #(.W(2), .DROP_W(8)) if_b ();
    bitorder_if #(.W(4), .DROP_W(2)) if_c ();

    bitorder_gen #(.W(4), .K(2), .DROP_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    bitorder_gen #(.W(2), .K(4), .DROP_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    bitorder_gen #(.W(4), .K(2), .DROP_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b", tag, actual, expected);
        end
    endtask

    task automatic idleAll();
        if_a.axiiv = 1'b0; if_a.axiid = '0;
        if_b.axiiv = 1'b0; if_b.axiid = '0;
        if_c.axiiv = 1'b0; if_c.axiid = '0;
    endtask

    // Drives one cycle of input on the selected instance, then samples 1ns after the edge.
    task automatic applyStimulus(input int sel, input logic v, input logic [3:0] d,
                                 input logic [1:0] m);
        @(negedge clk);
        idleAll();
        case (sel)
            0: begin if_a.axiiv = v; if_a.axiid = d;      if_a.mode = mode_e'(m); end
            1: begin if_b.axiiv = v; if_b.axiid = d[1:0]; if_b.mode = mode_e'(m); end
            default: begin if_c.axiiv = v; if_c.axiid = d; if_c.mode = mode_e'(m); end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input int sel, input string tag, input logic v,
                             input logic [3:0] d);
        case (sel)
            0: begin
                checkOutput({tag, "_v"}, 32'(if_a.axiov), 32'(v));
                checkOutput({tag, "_d"}, 32'(if_a.axiod), 32'(d));
            end
            1: begin
                checkOutput({tag, "_v"}, 32'(if_b.axiov), 32'(v));
                checkOutput({tag, "_d"}, 32'(if_b.axiod), 32'(d[1:0]));
            end
            default: begin
                checkOutput({tag, "_v"}, 32'(if_c.axiov), 32'(v));
                checkOutput({tag, "_d"}, 32'(if_c.axiod), 32'(d));
            end
        endcase
    endtask

    // The emitter must never be handed a new word while chunks are still owed.
    always begin
        @(negedge clk);
        #3;
        if (rst_n === 1'b1) begin
            if (dut_a.load) checkOutput("a_reload_busy", 32'(dut_a.u_emit.pos), 32'd0);
            if (dut_b.load) checkOutput("b_reload_busy", 32'(dut_b.u_emit.pos), 32'd0);
            if (dut_c.load) checkOutput("c_reload_busy", 32'(dut_c.u_emit.pos), 32'd0);
        end
    end

    logic [3:0] t2_in  [6] = '{4'b0101, 4'b1101, 4'b0001, 4'b1010, 4'b1100, 4'b1101};
    logic [3:0] t2_out [6] = '{4'b1101, 4'b0101, 4'b1010, 4'b0001, 4'b1101, 4'b1100};
    logic [3:0] t4_in  [4] = '{4'b01, 4'b10, 4'b11, 4'b00};
    logic [3:0] t4_rev [4] = '{4'b00, 4'b11, 4'b01, 4'b10};

    initial begin
        rst_n = 1'b0;
        idleAll();
        if_a.mode = MODE_PASS; if_b.mode = MODE_PASS; if_c.mode = MODE_PASS;
        @(negedge clk);
        @(negedge clk);
        expectOut(0, "rst_a", 1'b0, 4'b0000);
        expectOut(1, "rst_b", 1'b0, 4'b0000);
        checkOutput("rst_drop_a", 32'(if_a.drop), 32'd0);
        checkOutput("rst_cnt_a", 32'(if_a.drop_count), 32'd0);
        checkOutput("rst_cnt_c", 32'(if_c.drop_count), 32'd0);
        rst_n = 1'b1;

        $display("[TB] t1: single word, reversed chunk order");
        applyStimulus(0, 1'b1, 4'b0101, 2'b01); expectOut(0, "t1_c0", 1'b0, 4'b0000);
        applyStimulus(0, 1'b1, 4'b1101, 2'b01); expectOut(0, "t1_o0", 1'b1, 4'b1101);
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t1_o1", 1'b1, 4'b0101);
        checkOutput("t1_drop", 32'(if_a.drop), 32'd0);
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t1_idle", 1'b0, 4'b0000);
        checkOutput("t1_drop2", 32'(if_a.drop), 32'd0);

        $display("[TB] t2: back-to-back words");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'b1, t2_in[i], 2'b01);
            if (i == 0) expectOut(0, "t2_first", 1'b0, 4'b0000);
            else        expectOut(0, $sformatf("t2_o%0d", i - 1), 1'b1, t2_out[i-1]);
        end
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t2_o5", 1'b1, t2_out[5]);
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t2_idle", 1'b0, 4'b0000);
        checkOutput("t2_cnt", 32'(if_a.drop_count), 32'd0);

        $display("[TB] t3: trailing partial word");
        applyStimulus(0, 1'b1, 4'b0101, 2'b01); expectOut(0, "t3_c0", 1'b0, 4'b0000);
        applyStimulus(0, 1'b1, 4'b1101, 2'b01); expectOut(0, "t3_o0", 1'b1, 4'b1101);
        applyStimulus(0, 1'b1, 4'b0100, 2'b01); expectOut(0, "t3_o1", 1'b1, 4'b0101);
        checkOutput("t3_nodrop", 32'(if_a.drop), 32'd0);
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t3_gap", 1'b0, 4'b0000);
        checkOutput("t3_drop", 32'(if_a.drop), 32'd1);
        checkOutput("t3_cnt", 32'(if_a.drop_count), 32'd1);
        applyStimulus(0, 1'b0, 4'b0000, 2'b01); expectOut(0, "t3_idle", 1'b0, 4'b0000);
        checkOutput("t3_drop_end", 32'(if_a.drop), 32'd0);
        checkOutput("t3_cnt_hold", 32'(if_a.drop_count), 32'd1);

        $display("[TB] t4: W=2 K=4 full reversal, mode latched on last chunk");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, t4_in[i], (i == 3) ? 2'b11 : 2'b00);
            if (i < 3) expectOut(1, $sformatf("t4a_c%0d", i), 1'b0, 4'b0000);
            else       expectOut(1, "t4a_o0", 1'b1, t4_rev[0]);
        end
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 1'b0, 4'b0000, 2'b00);
            expectOut(1, $sformatf("t4a_o%0d", i), 1'b1, t4_rev[i]);
        end
        applyStimulus(1, 1'b0, 4'b0000, 2'b00); expectOut(1, "t4a_idle", 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, t4_in[i], 2'b00);
            if (i == 3) expectOut(1, "t4b_o0", 1'b1, t4_in[0]);
        end
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 1'b0, 4'b0000, 2'b11);
            expectOut(1, $sformatf("t4b_o%0d", i), 1'b1, t4_in[i]);
        end
        applyStimulus(1, 1'b0, 4'b0000, 2'b00); expectOut(1, "t4b_idle", 1'b0, 4'b0000);

        $display("[TB] t5: async reset mid-emission");
        applyStimulus(0, 1'b1, 4'b0011, 2'b00);
        applyStimulus(0, 1'b1, 4'b0110, 2'b00); expectOut(0, "t5_o0", 1'b1, 4'b0011);
        #1 rst_n = 1'b0;
        idleAll();
        #1;
        expectOut(0, "t5_rst", 1'b0, 4'b0000);
        checkOutput("t5_rst_cnt", 32'(if_a.drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 4'b0000, 2'b00);
            expectOut(0, $sformatf("t5_quiet%0d", i), 1'b0, 4'b0000);
        end
        applyStimulus(0, 1'b1, 4'b1001, 2'b00); expectOut(0, "t5_c0", 1'b0, 4'b0000);
        applyStimulus(0, 1'b1, 4'b1111, 2'b00); expectOut(0, "t5_n0", 1'b1, 4'b1001);
        applyStimulus(0, 1'b0, 4'b0000, 2'b00); expectOut(0, "t5_n1", 1'b1, 4'b1111);
        applyStimulus(0, 1'b0, 4'b0000, 2'b00); expectOut(0, "t5_idle", 1'b0, 4'b0000);
        checkOutput("t5_cnt", 32'(if_a.drop_count), 32'd0);

        $display("[TB] t6: saturating drop counter");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2, 1'b1, 4'b1010, 2'b00);
            checkOutput($sformatf("t6_nodrop%0d", k), 32'(if_c.drop), 32'd0);
            applyStimulus(2, 1'b0, 4'b0000, 2'b00);
            checkOutput($sformatf("t6_drop%0d", k), 32'(if_c.drop), 32'd1);
            checkOutput($sformatf("t6_cnt%0d", k), 32'(if_c.drop_count),
                        (k < 3) ? 32'(k + 1) : 32'd3);
            checkOutput($sformatf("t6_ov%0d", k), 32'(if_c.axiov), 32'd0);
        end
        applyStimulus(2, 1'b0, 4'b0000, 2'b00);
        checkOutput("t6_drop_end", 32'(if_c.drop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
